// File: rtl/multi_channel_pwm_if.sv
// rtl/multi_channel_pwm_if.sv - configuration bus for the multi-channel PWM
//
// Purpose: groups the shadow-register write and commit handshake.
// Signals:
//   cfg_valid / cfg_ready        channel write request / accept (ready = !commit_pending)
//   cfg_channel, cfg_duty,       channel write payload
//   cfg_phase
//   cfg_period_valid, cfg_period period write request and payload
//   commit / commit_pending      shadow-to-active transfer request / in-flight flag
// Modports: master drives requests, slave (the PWM) drives ready/pending.
interface multi_channel_pwm_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CW-1:0]  cfg_channel;
  logic [WIDTH:0] cfg_duty;
  logic [WIDTH-1:0] cfg_phase;
  logic           cfg_period_valid;
  logic [WIDTH:0] cfg_period;
  logic           commit;
  logic           commit_pending;

  modport master (
    output cfg_valid, cfg_channel, cfg_duty, cfg_phase,
    output cfg_period_valid, cfg_period, commit,
    input  cfg_ready, commit_pending
  );

  modport slave (
    input  cfg_valid, cfg_channel, cfg_duty, cfg_phase,
    input  cfg_period_valid, cfg_period, commit,
    output cfg_ready, commit_pending
  );
endinterface

// File: rtl/multi_channel_pwm.sv
// rtl/multi_channel_pwm.sv - multi-channel PWM with shared counter and atomic commit
//
// Purpose: CHANNELS PWM outputs driven from one period counter. Each channel
// has its own duty and phase; all configuration lands in shadow registers and
// is copied to the active set together at a period wrap.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset
//   enable        run the counter; low forces counter to 0 and outputs low
//   center_mode   (PWM_CENTER_ALIGN_EN only) centre each pulse in the period
//   cfg           multi_channel_pwm_if.slave configuration bus
//   pwm           registered PWM outputs, one per channel
//   period_start  registered, high when pwm reflects count 0
// Optional feature macro: PWM_CENTER_ALIGN_EN
module multi_channel_pwm #(
  parameter int CHANNELS       = 4,
  parameter int WIDTH          = 8,
  parameter int INITIAL_PERIOD = 256,
  parameter int INITIAL_DUTY   = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
`ifdef PWM_CENTER_ALIGN_EN
  input  logic                center_mode,
`endif
  multi_channel_pwm_if.slave  cfg,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);
  localparam int CW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH:0] INIT_P  = (WIDTH+1)'(INITIAL_PERIOD);
  localparam logic [WIDTH:0] INIT_D  = (WIDTH+1)'(INITIAL_DUTY);
  localparam logic [WIDTH:0] PER_ONE = (WIDTH+1)'(1);

  // Counter is WIDTH+1 bits so any storable period (even above 2^WIDTH) counts correctly.
  logic [WIDTH:0]   count_q, count_d;
  logic [WIDTH:0]   period_q, period_d, period_sh_q, period_sh_d;
  logic [WIDTH:0]   duty_q [CHANNELS];
  logic [WIDTH:0]   duty_d [CHANNELS];
  logic [WIDTH:0]   duty_sh_q [CHANNELS];
  logic [WIDTH:0]   duty_sh_d [CHANNELS];
  logic [WIDTH-1:0] phase_q [CHANNELS];
  logic [WIDTH-1:0] phase_d [CHANNELS];
  logic [WIDTH-1:0] phase_sh_q [CHANNELS];
  logic [WIDTH-1:0] phase_sh_d [CHANNELS];
  logic             pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic             start_q, start_d;
  logic             wrap, commit_acc, apply, center_en;

`ifdef PWM_CENTER_ALIGN_EN
  assign center_en = center_mode;
`else
  assign center_en = 1'b0;
`endif

  // One channel's output for count c. Edge mode is the centred form with offset 0.
  // c+p-ph is taken modulo 2^(WIDTH+1); the true result is below p so it is exact.
  function automatic logic chan_out(input logic [WIDTH:0] c, input logic [WIDTH:0] p,
                                    input logic [WIDTH:0] d, input logic [WIDTH-1:0] ph_raw,
                                    input logic ctr);
    logic [WIDTH:0] ph, e, o;
    ph = ({1'b0, ph_raw} >= p) ? '0 : {1'b0, ph_raw};
    e  = (c >= ph) ? (c - ph) : (c + p - ph);
    if (d >= p) return 1'b1;
    o  = ctr ? ((p - d) >> 1) : '0;
    return (e >= o) && (e < (o + d));
  endfunction

  always_comb begin
    wrap        = enable && (count_q == (period_q - 1'b1));
    commit_acc  = cfg.commit && !pending_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    phase_sh_d  = phase_sh_q;
    // Channel indices beyond CHANNELS match no slot, so such writes are dropped.
    if (cfg.cfg_valid && !pending_q) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (cfg.cfg_channel == CW'(i)) begin
          duty_sh_d[i]  = cfg.cfg_duty;
          phase_sh_d[i] = cfg.cfg_phase;
        end
      end
    end
    if (cfg.cfg_period_valid && !pending_q)
      period_sh_d = (cfg.cfg_period == '0) ? PER_ONE : cfg.cfg_period;

    // Apply uses the _d shadow values so writes accepted alongside the commit are included.
    apply     = (pending_q || commit_acc) && (wrap || !enable);
    pending_d = (pending_q || commit_acc) && !apply;
    period_d  = period_q;
    duty_d    = duty_q;
    phase_d   = phase_q;
    if (apply) begin
      period_d = period_sh_d;
      duty_d   = duty_sh_d;
      phase_d  = phase_sh_d;
    end

    count_d = (!enable || wrap) ? '0 : count_q + 1'b1;
    start_d = enable && (count_q == '0);
    pwm_d   = '0;
    for (int i = 0; i < CHANNELS; i++)
      pwm_d[i] = enable && chan_out(count_q, period_q, duty_q[i], phase_q[i], center_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q     <= '0;
      period_q    <= INIT_P;
      period_sh_q <= INIT_P;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= INIT_D;
        duty_sh_q[i]  <= INIT_D;
        phase_q[i]    <= '0;
        phase_sh_q[i] <= '0;
      end
      pending_q <= 1'b0;
      pwm_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      count_q     <= count_d;
      period_q    <= period_d;
      period_sh_q <= period_sh_d;
      for (int i = 0; i < CHANNELS; i++) begin
        duty_q[i]     <= duty_d[i];
        duty_sh_q[i]  <= duty_sh_d[i];
        phase_q[i]    <= phase_d[i];
        phase_sh_q[i] <= phase_sh_d[i];
      end
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      start_q   <= start_d;
    end
  end

  assign pwm                = pwm_q;
  assign period_start       = start_q;
  assign cfg.commit_pending = pending_q;
  assign cfg.cfg_ready      = !pending_q;
endmodule

// File: doc/multi_channel_pwm.md
Name: multi_channel_pwm

Overview:
Parametrised multi-channel successor to the single-channel PWM generator. All CHANNELS outputs share one period counter. Each channel has its own duty cycle and phase offset. Configuration is written into shadow registers and committed atomically at a period boundary, so all channels change glitch-free on the same cycle. Feeds LED, motor and audio-DAC drivers in the same clock domain.

Parameters:
CHANNELS, 4, number of PWM outputs (1..16)
WIDTH, 8, counter width; period range 1..2^WIDTH clock cycles
INITIAL_PERIOD, 256, active/shadow period after reset
INITIAL_DUTY, 128, active/shadow duty of every channel after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-low reset (0 = in reset)
enable  input  1  run counter; low holds counter at 0 with outputs low
cfg_valid  input  1  channel write request
cfg_ready  output  1  combinational, = !commit_pending
cfg_channel  input  max(1,$clog2(CHANNELS))  target channel
cfg_duty  input  WIDTH+1  high time in cycles, 0..2^WIDTH
cfg_phase  input  WIDTH  phase offset in cycles
cfg_period_valid  input  1  period write request (gated by cfg_ready)
cfg_period  input  WIDTH+1  new period in cycles
commit  input  1  request shadow-to-active transfer
commit_pending  output  1  commit accepted, not yet applied
pwm  output  CHANNELS  registered PWM outputs
period_start  output  1  registered; high in the cycle pwm reflects count 0

Behaviour:
- Reset (async assert, sync release): counter=0, pwm=0, period_start=0, commit_pending=0. Active and shadow values: period=INITIAL_PERIOD, every duty=INITIAL_DUTY, every phase=0.
- Counter counts up 0..P-1, where P is the active period, then wraps to 0.
- Outputs are registered from the counter value: one cycle latency. period_start=1 exactly when the registered count is 0.
- Channel write: accepted when cfg_valid && cfg_ready. Writes shadow duty and phase of cfg_channel. cfg_channel >= CHANNELS: the write is accepted and dropped.
- Period write: accepted when cfg_period_valid && cfg_ready. cfg_period=0 is stored as 1. A simultaneous channel write is also accepted.
- Commit accepted when commit && !commit_pending; it sets commit_pending. Commit while pending is a no-op.
- Shadow writes accepted in the same cycle as the commit are included in that commit.
- Apply: on the cycle the counter wraps (count==P-1 and enable), all shadow values are copied to active. The new period starts with the new values, and commit_pending clears.
- A commit in the wrap cycle itself applies at that wrap.
- If enable=0, a pending commit applies on the next clock.
- Phase: effective count e = (c >= ph) ? c-ph : c+P-ph. An active phase >= P is treated as 0.
- Edge mode: pwm[i] = (e < duty_i). duty=0 gives constant low; duty >= P gives constant high, with no glitch at the wrap.
- enable low: counter forced to 0, pwm=0, period_start=0. Counting resumes from 0 on the first enabled cycle.
- Reset mid-operation: all state returns to reset values immediately, and a pending commit is discarded.
- All compares are unsigned; the phase arithmetic is WIDTH+1 bits wide so it never overflows.

Optional Feature:
Macro PWM_CENTER_ALIGN_EN.
- With it: adds input center_mode (1 bit, sampled live). When 1, each pulse is centred in the period: pwm[i] = (e >= o) && (e < o+duty_i), with o = floor((P-duty_i)/2) for duty_i < P. duty >= P gives constant high; duty=0 gives constant low.
- Without it: port absent, edge-aligned only, no extra logic.

Test Plan:
1. Defaults (CHANNELS=4, WIDTH=8): release reset, enable=1 -> all pwm high 128 cycles, low 128; period_start every 256 cycles; first period_start on first enabled edge.
2. Phase: ch1 duty=64 phase=64, commit -> following period ch1 rises exactly 64 cycles after period_start and stays high 64; ch0/2/3 unchanged.
3. Commit timing: commit at count 100 -> commit_pending=1, cfg_ready=0, writes during pending ignored; new values seen from next period_start, pending clears that cycle.
4. Duty bounds at P=256: duty 0 -> constant low; duty 256 and 300 -> constant high across 3 wraps, no low cycle.
5. Period: period 10, duty 3 -> 3 high/7 low. Period 0 -> stored 1, period_start every cycle, duty 1 gives constant high.
6. Async reset: drive reset low mid-period with commit pending -> pwm=0 before next clk edge; after release, defaults from test 1 and commit_pending=0.
   Center (macro on): P=10, duty 4 -> high at counts 3..6.
